// File: rtl/mem_bus_pkg.sv
// Shared types and bus constants for the native memory bus arbiter and its helpers.
package mem_bus_pkg;

  localparam int unsigned MEM_AW = 32;
  localparam int unsigned MEM_DW = 32;
  localparam int unsigned MEM_SW = MEM_DW / 8;

  localparam logic [MEM_DW-1:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request searching upward from last+1, wrapping.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int unsigned d = 1; d <= N; d++) begin
      logic [PW-1:0] k;
      k = PW'((32'(i_last) + d) % N);
      if (!o_any && i_req[k]) begin
        o_any    = 1'b1;
        o_gnt[k] = 1'b1;
        o_idx    = k;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the shared native memory bus; grant held until the transaction
// completes, aborts, or is forced complete by the watchdog.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned       NUM_REQ     = 2,
  parameter int unsigned       TIMEOUT_CYC = 1023,
  parameter logic [MEM_DW-1:0] ERR_RDATA   = DEFAULT_ERR_RDATA
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*MEM_AW-1:0] req_addr_i,
  input  logic [NUM_REQ*MEM_DW-1:0] req_wdata_i,
  input  logic [NUM_REQ*MEM_SW-1:0] req_wstrb_i,
  output logic [MEM_DW-1:0]         req_rdata_o,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      mem_valid_o,
  output logic [MEM_AW-1:0]         mem_addr_o,
  output logic [MEM_DW-1:0]         mem_wdata_o,
  output logic [MEM_SW-1:0]         mem_wstrb_o,
  input  logic [MEM_DW-1:0]         mem_rdata_i,
  input  logic                      mem_ready_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      timeout_o
);

  localparam int unsigned   PW      = $clog2(NUM_REQ);
  localparam int unsigned   CW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] EXP_CNT = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  arb_state_e        r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [PW-1:0]      r_last;
  logic [CW-1:0]      r_cnt;

  logic [MEM_AW-1:0]  w_addr  [NUM_REQ];
  logic [MEM_DW-1:0]  w_wdata [NUM_REQ];
  logic [MEM_SW-1:0]  w_wstrb [NUM_REQ];
  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [PW-1:0]      w_pick_idx;
  logic               w_any;
  logic               w_busy;
  logic               w_own_valid;
  logic               w_ack;
  logic               w_expire;
  logic               w_leave;

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_addr[k]  = req_addr_i[k*MEM_AW +: MEM_AW];
      w_wdata[k] = req_wdata_i[k*MEM_DW +: MEM_DW];
      w_wstrb[k] = req_wstrb_i[k*MEM_SW +: MEM_SW];
    end
  end

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .i_req  (req_valid_i),
    .i_last (r_last),
    .o_gnt  (w_pick_gnt),
    .o_idx  (w_pick_idx),
    .o_any  (w_any)
  );

  // r_last doubles as the owner index while BUSY; grant_o alone is cleared for DONE.
  always_comb begin
    w_busy      = (r_state == BUSY);
    w_own_valid = w_busy && req_valid_i[r_last];
    w_ack       = w_own_valid && mem_ready_i;
    w_expire    = (TIMEOUT_CYC != 0) && w_own_valid && !mem_ready_i && (r_cnt == EXP_CNT);
    w_leave     = w_busy && (!req_valid_i[r_last] || mem_ready_i || w_expire);

    mem_valid_o = w_own_valid && !w_expire;
    mem_addr_o  = w_busy ? w_addr[r_last]  : '0;
    mem_wdata_o = w_busy ? w_wdata[r_last] : '0;
    mem_wstrb_o = w_busy ? w_wstrb[r_last] : '0;
    req_ready_o = (w_ack || w_expire) ? (NUM_REQ'(1) << r_last) : '0;
    req_rdata_o = w_ack ? mem_rdata_i : (w_expire ? ERR_RDATA : '0);
    timeout_o   = w_expire;
    grant_o     = r_grant;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= PW'(NUM_REQ - 1);
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= BUSY;
            r_grant <= w_pick_gnt;
            r_last  <= w_pick_idx;
          end
        end
        BUSY: begin
          if (w_leave) begin
            r_state <= DONE;
            r_grant <= '0;
            r_cnt   <= '0;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed corner sequences and
// a randomized run against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int          N   = 3;
  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam logic [31:0] A0  = 32'h0000_1000;
  localparam logic [31:0] W0  = 32'h1111_1111;
  localparam logic [31:0] A1  = 32'h0300_0004;
  localparam logic [31:0] WD1 = 32'hA5A5_5A5A;

  logic          clk, rst_n;
  logic [N-1:0]  valid;
  logic [N*32-1:0] addr, wdata;
  logic [N*4-1:0]  wstrb;
  logic [31:0]   rdata_o, mem_addr, mem_wdata, mrdata;
  logic [N-1:0]  ready_o, grant;
  logic [3:0]    mem_wstrb;
  logic          mem_valid, mrdy, timeout;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(
    .NUM_REQ     (N),
    .TIMEOUT_CYC (T),
    .ERR_RDATA   (ERR)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (valid),
    .req_addr_i  (addr),
    .req_wdata_i (wdata),
    .req_wstrb_i (wstrb),
    .req_rdata_o (rdata_o),
    .req_ready_o (ready_o),
    .mem_valid_o (mem_valid),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_wstrb_o (mem_wstrb),
    .mem_rdata_i (mrdata),
    .mem_ready_i (mrdy),
    .grant_o     (grant),
    .timeout_o   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    logic [2:0]  v;
    logic [31:0] a1, wd1;
    logic [3:0]  ws1;
    logic        mr;
    logic [31:0] mrd;
    logic        emv;
    logic [31:0] ema, ewd;
    logic [3:0]  ews;
    logic [2:0]  erdy;
    logic [31:0] erd;
    logic [2:0]  egnt;
    logic        eto;
  } vec_t;

  function automatic vec_t mk(logic [2:0] v, logic [31:0] a1, logic [31:0] wd1, logic [3:0] ws1,
                              logic mr, logic [31:0] mrd, logic emv, logic [31:0] ema,
                              logic [31:0] ewd, logic [3:0] ews, logic [2:0] erdy,
                              logic [31:0] erd, logic [2:0] egnt, logic eto);
    vec_t r;
    r.v = v; r.a1 = a1; r.wd1 = wd1; r.ws1 = ws1; r.mr = mr; r.mrd = mrd;
    r.emv = emv; r.ema = ema; r.ewd = ewd; r.ews = ews; r.erdy = erdy; r.erd = erd;
    r.egnt = egnt; r.eto = eto;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = '0; addr = '0; wdata = '0; wstrb = '0; mrdy = 1'b0; mrdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {mem_valid, mem_addr, mem_wdata, mem_wstrb, ready_o, rdata_o, grant, timeout},
        '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[10];
  int   ccyc[6];
  int   cown[6];

  initial begin
    int nc, vcnt, tcnt;
    bit seen;
    int m_owner, m_last, m_wait;
    bit m_gap;
    logic [N-1:0] pend;
    logic        e_mv, e_to;
    logic [31:0] e_ma, e_wd, e_rd;
    logic [3:0]  e_ws;
    logic [2:0]  e_rdy, e_gnt;

    tbl[0] = mk(3'b000, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
    tbl[1] = mk(3'b001, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
    tbl[2] = mk(3'b001, '0, '0, '0, 1'b0, '0, 1'b1, A0, W0, '0, '0, '0, 3'b001, 1'b0);
    tbl[3] = mk(3'b001, '0, '0, '0, 1'b0, '0, 1'b1, A0, W0, '0, '0, '0, 3'b001, 1'b0);
    tbl[4] = mk(3'b001, '0, '0, '0, 1'b1, 32'h1234_5678, 1'b1, A0, W0, '0, 3'b001,
                32'h1234_5678, 3'b001, 1'b0);
    tbl[5] = mk(3'b000, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
    tbl[6] = mk(3'b010, A1, WD1, 4'b0011, 1'b0, '0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
    tbl[7] = mk(3'b010, A1, WD1, 4'b0011, 1'b1, 32'hFFFF_0000, 1'b1, A1, WD1, 4'b0011, 3'b010,
                32'hFFFF_0000, 3'b010, 1'b0);
    tbl[8] = mk(3'b000, A1, WD1, 4'b0011, 1'b0, '0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
    tbl[9] = mk(3'b000, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b0);

    do_reset();

    // vector table: single read with two wait states, then a write from requester 1
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      valid = tbl[i].v;
      addr  = {32'h0, tbl[i].a1, A0};
      wdata = {32'h0, tbl[i].wd1, W0};
      wstrb = {4'h0, tbl[i].ws1, 4'h0};
      mrdy  = tbl[i].mr;
      mrdata = tbl[i].mrd;
      #4;
      chk($sformatf("vec%0d mem_valid", i), mem_valid, tbl[i].emv);
      chk($sformatf("vec%0d mem_addr", i),  mem_addr,  tbl[i].ema);
      chk($sformatf("vec%0d mem_wdata", i), mem_wdata, tbl[i].ewd);
      chk($sformatf("vec%0d mem_wstrb", i), mem_wstrb, tbl[i].ews);
      chk($sformatf("vec%0d ready", i),     ready_o,   tbl[i].erdy);
      chk($sformatf("vec%0d rdata", i),     rdata_o,   tbl[i].erd);
      chk($sformatf("vec%0d grant", i),     grant,     tbl[i].egnt);
      chk($sformatf("vec%0d timeout", i),   timeout,   tbl[i].eto);
    end

    // fairness: req0 and req1 always valid, zero-wait slave
    nc = 0;
    valid = 3'b011; mrdy = 1'b1;
    for (int c = 0; c < 40 && nc < 6; c++) begin
      @(posedge clk); #1;
      mrdata = 32'hC000_0000 + c;
      #4;
      if (ready_o != '0) begin
        ccyc[nc] = c;
        cown[nc] = (ready_o == 3'b001) ? 0 : (ready_o == 3'b010) ? 1 : (ready_o == 3'b100) ? 2 : 9;
        chk($sformatf("rr_rdata%0d", nc), rdata_o, mrdata);
        nc++;
      end
    end
    chk("rr_count", nc, 6);
    for (int j = 0; j < nc; j++) begin
      chk($sformatf("rr_owner%0d", j), cown[j], j % 2);
      if (j > 0) chk($sformatf("rr_spacing%0d", j), ccyc[j] - ccyc[j-1], 3);
    end
    @(posedge clk); #1; valid = '0; mrdy = 1'b0;
    @(posedge clk); #1;

    // watchdog: slave never ready, req1 waiting behind req0
    valid = 3'b011; mrdy = 1'b0;
    vcnt = 0; tcnt = 0; seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(posedge clk); #5;
      if (mem_valid) vcnt++;
      if (timeout) tcnt++;
      if (ready_o != '0) begin
        seen = 1'b1;
        chk("wd_ready", ready_o, 3'b001);
        chk("wd_rdata", rdata_o, ERR);
        chk("wd_mem_valid", mem_valid, 1'b0);
      end
    end
    chk("wd_seen", seen, 1'b1);
    chk("wd_valid_cycles", vcnt, T - 1);
    @(posedge clk); #1; valid = 3'b010; #4;
    if (timeout) tcnt++;
    chk("wd_pulses", tcnt, 1);
    chk("wd_done_grant", grant, 3'b000);
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk); #1;
      if (grant != '0) seen = 1'b1;
    end
    chk("wd_next_grant", grant, 3'b010);
    mrdy = 1'b1; mrdata = 32'h0BAD_F00D; #4;
    chk("wd_next_ready", ready_o, 3'b010);
    @(posedge clk); #1; valid = '0; mrdy = 1'b0;
    @(posedge clk); #1;

    // ready arriving on the expiry cycle beats the watchdog
    valid = 3'b001; seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk); #1;
      if (grant == 3'b001) seen = 1'b1;
    end
    chk("co_grant", grant, 3'b001);
    for (int n = 1; n <= T; n++) begin
      mrdy = (n == T);
      mrdata = (n == T) ? 32'h0000_0001 : 32'h5555_5555;
      #4;
      if (n == T) begin
        chk("co_ready", ready_o, 3'b001);
        chk("co_rdata", rdata_o, 32'h0000_0001);
        chk("co_timeout", timeout, 1'b0);
      end else if (ready_o != '0) begin
        chk($sformatf("co_early_ready%0d", n), ready_o, 3'b000);
      end
      @(posedge clk); #1;
    end
    valid = '0; mrdy = 1'b0;

    // randomized traffic against the reference model
    do_reset();
    m_owner = -1; m_last = N - 1; m_wait = 0; m_gap = 1'b0; pend = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (pend[k]) begin
          if ($urandom_range(0, 59) == 0) pend[k] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          addr[32*k +: 32]  = $urandom;
          wdata[32*k +: 32] = $urandom;
          wstrb[4*k +: 4]   = 4'($urandom_range(0, 15));
        end
      end
      valid = pend;
      mrdy = ($urandom_range(0, 3) == 0);
      mrdata = $urandom;
      #4;
      e_mv = 1'b0; e_ma = '0; e_wd = '0; e_ws = '0; e_rdy = '0; e_rd = '0; e_gnt = '0; e_to = 1'b0;
      if (m_owner >= 0) begin
        e_ma  = addr[32*m_owner +: 32];
        e_wd  = wdata[32*m_owner +: 32];
        e_ws  = wstrb[4*m_owner +: 4];
        e_gnt = 3'(1 << m_owner);
        if (valid[m_owner] && mrdy) begin
          e_mv = 1'b1; e_rdy = 3'(1 << m_owner); e_rd = mrdata;
        end else if (valid[m_owner] && m_wait == T - 1) begin
          e_rdy = 3'(1 << m_owner); e_rd = ERR; e_to = 1'b1;
        end else begin
          e_mv = valid[m_owner];
        end
      end
      chk($sformatf("rand%0d", cyc),
          {mem_valid, mem_addr, mem_wdata, mem_wstrb, ready_o, rdata_o, grant, timeout},
          {e_mv, e_ma, e_wd, e_ws, e_rdy, e_rd, e_gnt, e_to});
      if (m_owner >= 0) begin
        if (!valid[m_owner] || mrdy || e_to) begin
          if (e_rdy != '0) pend[m_owner] = 1'b0;
          m_owner = -1;
          m_gap = 1'b1;
        end else begin
          m_wait++;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (valid != '0) begin
        for (int d = 1; d <= N && m_owner < 0; d++)
          if (valid[(m_last + d) % N]) m_owner = (m_last + d) % N;
        m_last = m_owner;
        m_wait = 0;
      end
    end

    // asynchronous reset in the middle of a busy transaction
    do_reset();
    valid = 3'b001; seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk); #1;
      if (grant == 3'b001) seen = 1'b1;
    end
    mrdy = 1'b1; mrdata = 32'h7777_0000; #1;
    chk("ar_pre_ready", ready_o, 3'b001);
    #1; rst_n = 1'b0; #1;
    chk("ar_mem_valid", mem_valid, 1'b0);
    chk("ar_grant", grant, 3'b000);
    chk("ar_ready", ready_o, 3'b000);
    valid = 3'b011; mrdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_first_grant", grant, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single native memory bus (valid/addr/wdata/wstrb/rdata/ready, valid held until ready) between NUM_REQ requesters, e.g. CPU core port and DMA engine.
- Sits between the core wrapper outputs plus other masters and the SoC interconnect/address decoder.
- Round-robin grant, locked until the transaction completes.
- Bus watchdog completes hung transactions with an error word.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 1023, cycles a granted transaction may wait for mem_ready_i before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on forced completion.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester valid.
- req_addr_i  in  NUM_REQ*32  packed addresses; requester k uses bits [32k+31:32k].
- req_wdata_i  in  NUM_REQ*32  packed write data.
- req_wstrb_i  in  NUM_REQ*4  packed byte strobes; 0 means read.
- req_rdata_o  out  32  read data, valid while req_ready_o[k] is high.
- req_ready_o  out  NUM_REQ  one-hot completion pulse to the owner.
- mem_valid_o  out  1  to the shared bus.
- mem_addr_o  out  32  to the shared bus.
- mem_wdata_o  out  32  to the shared bus.
- mem_wstrb_o  out  4  to the shared bus.
- mem_rdata_i  in  32  from the shared bus.
- mem_ready_i  in  1  from the shared bus.
- grant_o  out  NUM_REQ  current owner, one-hot; 0 when idle.
- timeout_o  out  1  one-cycle pulse on watchdog completion.

Behaviour:
- Reset values: all outputs 0; state IDLE; last-grant pointer = NUM_REQ-1, so requester 0 has first priority; watchdog counter 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If any req_valid_i bit is set, pick the first set bit searching from (last+1) mod NUM_REQ upward, with wrap-around.
  - Register grant_o and last pointer; go to BUSY next edge.
  - mem_valid_o is 0 in IDLE.
- BUSY:
  - mem_valid_o = req_valid_i[owner].
  - mem_addr_o, mem_wdata_o and mem_wstrb_o are combinational muxes of the owner's inputs.
  - Non-owners see req_ready_o = 0.
  - mem_ready_i=1: req_ready_o[owner]=1 and req_rdata_o=mem_rdata_i in the same cycle, combinational pass-through. Go to DONE.
  - Owner drops req_valid_i before ready (protocol violation/abort): go to DONE; no ready is issued.
  - Watchdog: counter increments each BUSY cycle without mem_ready_i. On reaching TIMEOUT_CYC-1:
    - mem_valid_o forced 0.
    - req_ready_o[owner]=1 with req_rdata_o=ERR_RDATA.
    - timeout_o=1.
    - Go to DONE.
    - Writes are dropped silently.
  - If mem_ready_i and expiry coincide, mem_ready_i wins; timeout_o stays 0.
- DONE: one-cycle turnaround. grant_o cleared, counter cleared, mem_valid_o=0, then IDLE. The requester observes its own valid drop during this cycle.
- Latency:
  - Request seen in IDLE at cycle 0 → mem_valid_o at cycle 1.
  - Minimum 3 cycles per transaction with a zero-wait slave; back-to-back throughput is 1 transaction per 3 cycles.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- Requests arriving during BUSY/DONE are not lost; they are sampled in the next IDLE cycle.
- Asynchronous reset mid-transaction:
  - All outputs drop to 0 immediately; any in-flight transaction is abandoned.
  - The slave must be reset in the same domain.
- Widths: counter is $clog2(TIMEOUT_CYC+1) bits and saturates; pointer is $clog2(NUM_REQ) bits.

Decomposition:
- Shared package mem_bus_pkg:
  - state enum arb_state_e {IDLE, BUSY, DONE}
  - localparam MEM_AW=32, MEM_DW=32
  - default ERR_RDATA
- Sub-module rr_pick:
  - Combinational round-robin priority finder.
  - Inputs: req vector, last pointer. Outputs: one-hot grant, index.
  - Reusable by the future IRQ and DMA-channel schedulers.

Test Plan:
- Single requester: req0 read addr 32'h0000_1000, slave ready after 2 cycles with rdata 32'h1234_5678 → mem_valid_o rises cycle 1; req_ready_o=2'b01 with rdata 32'h1234_5678; grant_o 0 in DONE.
- Both requesters continuously valid, zero-wait slave, 6 transactions → grant sequence 0,1,0,1,0,1; each completes 3 cycles apart.
- Write pass-through: req1 wstrb 4'b0011, wdata 32'hA5A5_5A5A, addr 32'h0300_0004 → mem outputs match exactly while req0 is idle; req_ready_o=2'b10.
- Watchdog with TIMEOUT_CYC=8, slave never ready → after 8 BUSY cycles: req_ready_o[owner]=1, rdata 32'hDEAD_BEEF, timeout_o pulses once, mem_valid_o=0; the next requester is then granted.
- Coincidence: mem_ready_i at the expiry cycle with rdata 32'h0000_0001 → data 1 returned, timeout_o=0.
- rst_n_i asserted mid-BUSY → mem_valid_o, grant_o, req_ready_o = 0 asynchronously. After release, req0 and req1 both pending → req0 is granted first.
